// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the clock divider bank.
//   CNT_W_DEF  : default divisor / counter width (120000 fits in 17 bits)
//   DIV_MIN    : smallest legal divisor
//   CH_IDX_W   : width of the configuration channel index
//   MAX_CH     : number of channels addressable by CH_IDX_W
//   div_t      : divisor type at the default width
//   ch_state_e : per-channel run state
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W_DEF = 17;
    localparam int DIV_MIN   = 2;
    localparam int CH_IDX_W  = 3;
    localparam int MAX_CH    = 1 << CH_IDX_W;

    typedef logic [CNT_W_DEF-1:0] div_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// -----------------------------------------------------------------------------
// clk_div_bank_if
// Divisor configuration handshake for clk_div_bank.
//   cfg_valid : divisor write request            (master -> slave)
//   cfg_ch    : target channel index              (master -> slave)
//   cfg_div   : new divisor                       (master -> slave)
//   cfg_ready : write accepted when valid && ready (slave -> master)
//   cfg_err   : one-cycle pulse after an illegal write (slave -> master)
// -----------------------------------------------------------------------------
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic                cfg_valid;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic                cfg_ready;
    logic                cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divider channel: counter 0..D-1, 50 % duty output with a negedge
// half-cycle extension for odd D, period-start tick, and a pending divisor
// that is only applied at a period boundary (or immediately when idle).
//   clk_12mhz : source clock
//   reset     : asynchronous active-high reset
//   enable    : run enable (level); disabling lets the current period finish
//   sync      : restart in phase (only honoured while enabled)
//   wr_en     : accepted divisor write for this channel
//   wr_div    : divisor carried by the write
//   pend      : a divisor write is waiting to be applied
//   clk_out   : divided clock
//   clk_out_n : inverse of clk_out
//   tick      : one-cycle pulse at each period start
// -----------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF   = CNT_W'(DIV_MIN)
) (
    input  logic             clk_12mhz,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             clk_out_n,
    output logic             tick
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             neg_q;

    logic             wrap;
    logic             start;
    logic             load;

    assign wrap = (cnt_q == (div_q - CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        start   = 1'b0;
        load    = 1'b0;

        case (state_q)
            CH_IDLE: begin
                // Idle: a pending divisor may be applied right away.
                cnt_d = '0;
                load  = 1'b1;
                if (enable) begin
                    start = 1'b1;
                end
            end
            CH_RUN: begin
                if (enable && sync) begin
                    start = 1'b1;
                end else if (wrap) begin
                    load = 1'b1;
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
            end
        endcase

        // A single start path covers enable rise, wrap and sync, so a sync
        // coinciding with an enable rise produces exactly one start.
        if (start) begin
            state_d = CH_RUN;
            cnt_d   = '0;
            tick_d  = 1'b1;
            load    = 1'b1;
        end

        if (load && pend_q) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
        end

        // Applied after the load so a write landing on a wrap or sync stays
        // pending for the following boundary.
        if (wr_en) begin
            pend_d = 1'b1;
            pdiv_d = wr_div;
        end

        // High for the first floor(D/2) counts; the odd half-cycle is added
        // by the negedge flop.
        pos_d = (state_d == CH_RUN) && (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            div_q   <= DEF;
            pdiv_q  <= '0;
            pend_q  <= 1'b0;
            pos_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
        end
    end

    // Delayed copy of the posedge duty flop by half a cycle. ORed in only for
    // odd divisors; it overlaps pos_q at the posedge fall, so no glitch.
    always_ff @(negedge clk_12mhz or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out   = pos_q | (neg_q & div_q[0]);
    assign clk_out_n = ~clk_out;
    assign tick      = tick_q;
    assign pend      = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of N_CH independent clock dividers sharing one configuration port.
// This level only decodes divisor writes, produces cfg_ready / cfg_err, and
// fans sync out to the channels.
//   clk_12mhz : source clock
//   reset     : asynchronous active-high reset
//   enable    : per-channel run enable
//   sync      : restart all enabled channels in phase
//   cfg       : divisor write handshake (slave side)
//   clk_out   : divided clocks
//   clk_out_n : inverse of clk_out
//   tick      : per-channel period-start pulses
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                    N_CH    = 2,
    parameter int                    CNT_W   = CNT_W_DEF,
    parameter logic [N_CH*CNT_W-1:0] DEF_DIV = {div_t'(120000), div_t'(3)}
) (
    input  logic            clk_12mhz,
    input  logic            reset,
    input  logic [N_CH-1:0] enable,
    input  logic            sync,
    clk_div_bank_if.slave   cfg,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] clk_out_n,
    output logic [N_CH-1:0] tick
);

    localparam logic [CH_IDX_W:0] N_CH_W = (CH_IDX_W+1)'(N_CH);

    logic [N_CH-1:0]   pend;
    logic [MAX_CH-1:0] pend_ext;
    logic [N_CH-1:0]   wr_en;
    logic              ch_ok;
    logic              div_ok;
    logic              hs;
    logic              err_d;
    logic              err_q;

    // Unimplemented channel indices read as "not pending" so that an
    // out-of-range write is accepted and then flagged rather than stalled.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_CH; gi++) begin : g_pend
            if (gi < N_CH) begin : g_used
                assign pend_ext[gi] = pend[gi];
            end else begin : g_unused
                assign pend_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ch_ok         = ({1'b0, cfg.cfg_ch} < N_CH_W);
    assign div_ok        = (cfg.cfg_div >= CNT_W'(DIV_MIN));
    assign cfg.cfg_ready = ~pend_ext[cfg.cfg_ch];
    assign hs            = cfg.cfg_valid & cfg.cfg_ready;
    assign err_d         = hs & ~(ch_ok & div_ok);

    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg.cfg_err = err_q;

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign wr_en[gi] = hs & ch_ok & div_ok & (cfg.cfg_ch == CH_IDX_W'(gi));

            clk_div_ch #(
                .CNT_W (CNT_W),
                .DEF   (DEF_DIV[gi*CNT_W +: CNT_W])
            ) u_ch (
                .clk_12mhz (clk_12mhz),
                .reset     (reset),
                .enable    (enable[gi]),
                .sync      (sync),
                .wr_en     (wr_en[gi]),
                .wr_div    (cfg.cfg_div),
                .pend      (pend[gi]),
                .clk_out   (clk_out[gi]),
                .clk_out_n (clk_out_n[gi]),
                .tick      (tick[gi])
            );
        end
    endgenerate

endmodule
